// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the inverse key expander and the inverse cipher round engine.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ready,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// Sequential inverse AES-128 key expander: starts from the round-10 key and walks the
// schedule backward, presenting one round key per accepted handshake (10 down to 0).
module inv_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic               clk,
  input logic               rst,
  inv_key_schedule_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // Forward AES S-box, byte 0x00 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] hi;
    hi = 11'h7ff - {b, 3'b000};
    return SboxTable[hi -: 8];
  endfunction

  function automatic logic [31:0] s_box_4(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round_number);
    logic [7:0] rc;
    rc = 8'h00;
    unique case (round_number)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic [127:0] prev_key;

  // Undo one forward step; rcon uses the round that produced the current key.
  always_comb begin
    logic [31:0] k0, k1, k2, k3, p0, p1, p2, p3;
    k0 = key_q[127:96];
    k1 = key_q[95:64];
    k2 = key_q[63:32];
    k3 = key_q[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    p0 = k0 ^ s_box_4({p3[23:0], p3[31:24]}) ^ {rcon(rnd_q), 24'h000000};
    prev_key = {p0, p1, p2, p3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          key_d   = bus.last_key;
          rnd_d   = 4'(NUM_ROUNDS);
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.key_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = prev_key;
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.key_valid = (state_q == StEmit);
    bus.busy      = (state_q == StEmit);
    bus.round_key = key_q;
    bus.round_num = rnd_q;
    bus.done      = done_q;
  end

endmodule
